// File: rtl/contador_if.sv
// contador_if: request/response bus between the counter reader and the counter block
//   req            - read request, one cycle per counter read (master -> slave)
//   idx            - counter index accompanying req (master -> slave)
//   valid_contador - responder read-valid, level and sticky (slave -> master)
//   contador_in    - responder counter value (slave -> master)
interface contador_if;
   logic       req;
   logic [2:0] idx;
   logic       valid_contador;
   logic [4:0] contador_in;
   modport master (output req, idx, input valid_contador, contador_in);
   modport slave (input req, idx, output valid_contador, contador_in);
endinterface

// File: rtl/contador_reader.sv
// contador_reader: sweeps four counters over a req/valid bus, with idle gating and per-read timeout
//   clk, reset        - clock, asynchronous active-high reset
//   start             - single-cycle sweep request, ignored while busy
//   idle_in           - system idle; a read is only requested while it is high
//   bus               - master side of contador_if (req/idx out, valid_contador/contador_in in)
//   count_0..count_3  - captured counter values
//   total             - sum of the four counts, updated at sweep end
//   busy, done        - sweep in progress, one-cycle end-of-sweep pulse
//   timeout_err       - a read timed out, remaining lanes left at 0
module contador_reader #(
   parameter int TIMEOUT = 8,
   parameter int NUM_CTR = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             idle_in,
   contador_if.master       bus,
   output logic [4:0]       count_0,
   output logic [4:0]       count_1,
   output logic [4:0]       count_2,
   output logic [4:0]       count_3,
   output logic [6:0]       total,
   output logic             busy,
   output logic             done,
   output logic             timeout_err
);
   typedef enum logic [2:0] {S_IDLE, S_WAIT_IDLE, S_REQ, S_WAIT_VALID, S_DONE} state_t;
   state_t           state_q, state_d;
   logic [1:0]       lane_q, lane_d;
   logic [3:0]       timer_q, timer_d;
   logic [3:0][4:0]  cnt_q, cnt_d;
   logic [6:0]       total_q, total_d;
   logic             terr_q, terr_d;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         lane_q  <= '0;
         timer_q <= '0;
         cnt_q   <= '0;
         total_q <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
         terr_q  <= terr_d;
      end
   end
   // valid is only looked at in S_WAIT_VALID, so a sticky valid left over from the
   // previous read is harmless during the S_REQ cycle
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      total_d = total_q;
      terr_d  = terr_q;
      case (state_q)
         S_IDLE:
            if (start) begin
               cnt_d   = '0;
               total_d = '0;
               terr_d  = 1'b0;
               lane_d  = '0;
               state_d = idle_in ? S_REQ : S_WAIT_IDLE;
            end
         S_WAIT_IDLE:
            state_d = idle_in ? S_REQ : S_WAIT_IDLE;
         S_REQ: begin
            timer_d = '0;
            state_d = S_WAIT_VALID;
         end
         S_WAIT_VALID:
            if (bus.valid_contador) begin
               cnt_d[lane_q] = bus.contador_in;
               lane_d  = lane_q == 2'(NUM_CTR - 1) ? lane_q : lane_q + 2'd1;
               state_d = lane_q == 2'(NUM_CTR - 1) ? S_DONE : (idle_in ? S_REQ : S_WAIT_IDLE);
            end else if (timer_q == 4'(TIMEOUT - 1)) begin
               terr_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               timer_d = timer_q + 4'd1;
            end
         S_DONE: begin
            total_d = {2'b0, cnt_q[0]} + {2'b0, cnt_q[1]} + {2'b0, cnt_q[2]} + {2'b0, cnt_q[3]};
            state_d = S_IDLE;
         end
         default:
            state_d = S_IDLE;
      endcase
   end
   assign bus.req     = state_q == S_REQ;
   assign bus.idx     = state_q == S_IDLE ? 3'd0 : {1'b0, lane_q};
   assign busy        = state_q != S_IDLE;
   assign done        = state_q == S_DONE;
   assign timeout_err = terr_q;
   assign total       = total_q;
   assign count_0     = cnt_q[0];
   assign count_1     = cnt_q[1];
   assign count_2     = cnt_q[2];
   assign count_3     = cnt_q[3];
endmodule

// File: tb/tb_contador_reader.sv
// tb_contador_reader: table, hand-written and randomized sweeps against a lane-level reference model
module tb_contador_reader;
   localparam int TIMEOUT = 8;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       idle_in = 1'b1;
   logic [4:0] count_0, count_1, count_2, count_3;
   logic [6:0] total;
   logic       busy, done, timeout_err;
   contador_if bus ();
   contador_reader #(.TIMEOUT(TIMEOUT), .NUM_CTR(4)) dut (
      .clk(clk), .reset(reset), .start(start), .idle_in(idle_in), .bus(bus),
      .count_0(count_0), .count_1(count_1), .count_2(count_2), .count_3(count_3),
      .total(total), .busy(busy), .done(done), .timeout_err(timeout_err)
   );
   always #5 clk = ~clk;
   int n_cmp = 0;
   int n_bad = 0;
   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask
   // responder: delay d means valid rises d cycles after the first wait cycle; 255 never
   logic [4:0] rv [4];
   int         rd [4];
   logic       hold_valid = 1'b0;
   int         cd = 255;
   always @(posedge clk) begin
      logic       rq;
      logic [1:0] ri;
      rq = bus.req;
      ri = bus.idx[1:0];
      #1;
      if (rq) begin
         cd = rd[ri];
         bus.contador_in = rv[ri];
      end else if (cd > 0 && cd != 255) cd--;
      if ($isunknown(bus.contador_in)) bus.contador_in = '0;
      if (bus.req === 1'b1) bus.contador_in = rv[bus.idx[1:0]] ^ 5'h15;
      bus.valid_contador = hold_valid || cd == 0;
   end
   function automatic void model(input logic [3:0][4:0] v, input logic [3:0][7:0] d,
                                 output logic [3:0][4:0] ec, output int tot, output int terr,
                                 output int lanes, output int lat);
      ec = '0; tot = 0; terr = 0; lanes = 0; lat = 1;
      for (int i = 0; i < 4; i++)
         if (terr == 0) begin
            lanes++;
            if (int'(d[i]) < TIMEOUT) begin
               ec[i] = v[i];
               tot += int'(v[i]);
               lat += int'(d[i]) + 2;
            end else begin
               terr = 1;
               lat += TIMEOUT + 1;
            end
         end
   endfunction
   typedef struct {
      logic [3:0][4:0] v;
      logic [3:0][7:0] d;
      logic [3:0][4:0] ec;
      int              etot;
      int              eterr;
      int              elat;
   } vec_t;
   function automatic vec_t mk(input int v0, v1, v2, v3, d0, d1, d2, d3,
                               c0, c1, c2, c3, tot, terr, lat);
      vec_t t;
      t.v  = {5'(v3), 5'(v2), 5'(v1), 5'(v0)};
      t.d  = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
      t.ec = {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
      t.etot = tot; t.eterr = terr; t.elat = lat;
      return t;
   endfunction
   task automatic sweep(input string tag, input logic [3:0][4:0] v, input logic [3:0][7:0] d,
                        input int rnd_idle, input logic [3:0][4:0] ec, input int etot,
                        input int eterr, input int elanes, input int elat);
      int reqs[$];
      int lat;
      logic [3:0][4:0] got;
      for (int i = 0; i < 4; i++) begin rv[i] = v[i]; rd[i] = int'(d[i]); end
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 400 && lat == 0; c++) begin
         if (rnd_idle != 0) idle_in = $urandom_range(0, 9) < 7;
         @(negedge clk);
         if (bus.req) reqs.push_back(int'(bus.idx));
         chk({tag, " busy"}, int'(busy), 1);
         if (done) lat = c;
         @(posedge clk); #1;
      end
      idle_in = 1'b1;
      chk({tag, " done_seen"}, int'(lat != 0), 1);
      if (rnd_idle == 0) chk({tag, " latency"}, lat, elat);
      chk({tag, " req_count"}, reqs.size(), elanes);
      foreach (reqs[i]) chk($sformatf("%s req_idx%0d", tag, i), reqs[i], i);
      repeat (2) begin
         @(negedge clk);
         chk({tag, " done_after"}, int'(done), 0);
         chk({tag, " busy_after"}, int'(busy), 0);
      end
      got = {count_3, count_2, count_1, count_0};
      for (int i = 0; i < 4; i++) chk($sformatf("%s count_%0d", tag, i), int'(got[i]), int'(ec[i]));
      chk({tag, " total"}, int'(total), etot);
      chk({tag, " timeout_err"}, int'(timeout_err), eterr);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
   initial begin
      vec_t tbl[$];
      logic [3:0][4:0] ec;
      logic [3:0][7:0] d;
      logic [3:0][4:0] v;
      int tot, terr, lanes, lat, found, ndone, dcyc;
      for (int i = 0; i < 4; i++) begin rv[i] = '0; rd[i] = 255; end
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst req", int'(bus.req), 0);
      chk("rst idx", int'(bus.idx), 0);
      chk("rst total", int'(total), 0);
      chk("rst terr", int'(timeout_err), 0);
      chk("rst counts", int'({count_3, count_2, count_1, count_0}), 0);
      reset = 1'b0;
      tbl.push_back(mk(3, 5, 0, 31, 0, 0, 0, 0, 3, 5, 0, 31, 39, 0, 9));
      tbl.push_back(mk(31, 31, 31, 31, 0, 0, 0, 0, 31, 31, 31, 31, 124, 0, 9));
      tbl.push_back(mk(1, 2, 3, 4, 7, 0, 0, 0, 1, 2, 3, 4, 10, 0, 16));
      tbl.push_back(mk(3, 5, 7, 9, 0, 0, 255, 0, 3, 5, 0, 0, 8, 1, 14));
      tbl.push_back(mk(10, 11, 12, 13, 255, 255, 255, 255, 0, 0, 0, 0, 0, 1, 10));
      tbl.push_back(mk(0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 15));
      tbl.push_back(mk(20, 21, 22, 23, 0, 0, 0, 8, 20, 21, 22, 0, 63, 1, 16));
      foreach (tbl[k]) begin
         model(tbl[k].v, tbl[k].d, ec, tot, terr, lanes, lat);
         sweep($sformatf("tbl%0d", k), tbl[k].v, tbl[k].d, 0, tbl[k].ec, tbl[k].etot,
               tbl[k].eterr, lanes, tbl[k].elat);
      end
      // idle_in low at start, raised six cycles later
      for (int i = 0; i < 4; i++) begin rv[i] = 5'(i + 1); rd[i] = 0; end
      @(posedge clk); #1;
      idle_in = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         chk("idlewait busy", int'(busy), 1);
         chk("idlewait req", int'(bus.req), 0);
         @(posedge clk); #1;
      end
      idle_in = 1'b1;
      @(negedge clk);
      chk("idlewait req_on_rise", int'(bus.req), 0);
      @(negedge clk);
      chk("idlewait first_req", int'(bus.req), 1);
      chk("idlewait first_idx", int'(bus.idx), 0);
      found = 0;
      for (int c = 0; c < 60 && found == 0; c++) begin
         @(negedge clk);
         if (done) found = 1;
      end
      chk("idlewait done_seen", found, 1);
      @(negedge clk);
      chk("idlewait total", int'(total), 10);
      // valid held high across the whole sweep
      hold_valid = 1'b1;
      repeat (3) @(posedge clk);
      v = {5'd4, 5'd17, 5'd30, 5'd9};
      d = {8'd255, 8'd255, 8'd255, 8'd255};
      sweep("holdvalid", v, d, 0, v, 60, 0, 4, 9);
      hold_valid = 1'b0;
      // reset while idx=1 is outstanding
      for (int i = 0; i < 4; i++) begin rv[i] = 5'(3 + i); rd[i] = 2; end
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 60 && found == 0; c++) begin
         @(negedge clk);
         if (bus.req && bus.idx == 3'd1) found = 1;
      end
      chk("rstmid reached_idx1", found, 1);
      chk("rstmid pre_count_0", int'(count_0), 3);
      reset = 1'b1;
      #1;
      chk("rstmid busy", int'(busy), 0);
      chk("rstmid req", int'(bus.req), 0);
      chk("rstmid idx", int'(bus.idx), 0);
      chk("rstmid count_0", int'(count_0), 0);
      chk("rstmid total", int'(total), 0);
      chk("rstmid done", int'(done), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy) ndone += 100;
      end
      chk("rstmid no_done_no_busy", ndone, 0);
      model(tbl[0].v, tbl[0].d, ec, tot, terr, lanes, lat);
      sweep("rstmid resweep", tbl[0].v, tbl[0].d, 0, tbl[0].ec, tbl[0].etot, tbl[0].eterr, lanes, tbl[0].elat);
      // start while busy and during the S_DONE cycle
      for (int i = 0; i < 4; i++) begin rv[i] = 5'(7 * i + 2); rd[i] = 0; end
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; dcyc = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin ndone++; if (dcyc == 0) dcyc = c; end
         @(posedge clk); #1;
         start = c == 3 || c == 8;
      end
      chk("restart done_count", ndone, 1);
      chk("restart done_cycle", dcyc, 9);
      chk("restart busy_end", int'(busy), 0);
      chk("restart total", int'(total), 2 + 9 + 16 + 23);
      // randomized sweeps against the model
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 4; i++) begin
            v[i] = 5'($urandom_range(0, 31));
            d[i] = $urandom_range(0, 9) == 9 ? 8'd255 : 8'($urandom_range(0, TIMEOUT));
         end
         model(v, d, ec, tot, terr, lanes, lat);
         sweep($sformatf("rnd%0d", it), v, d, it % 2, ec, tot, terr, lanes, lat);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
